// File: rtl/mfb_merger_arbiter_pkg.sv
// rtl/mfb_merger_arbiter_pkg.sv - shared types, constants and helpers for the MFB merger arbiter
package mfb_merger_arbiter_pkg;

  localparam int INPUTS      = 2;
  // Upper bound on REGIONS, used to size the popcount argument.
  localparam int MAX_REGIONS = 16;

  typedef logic [0:0] input_idx_t;

  // Number of set bits in a region-wide flag vector.
  function automatic logic [7:0] popcount(input logic [MAX_REGIONS-1:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < MAX_REGIONS; i++) begin
      n = n + 8'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/mfb_frame_tracker.sv
// rtl/mfb_frame_tracker.sv - per-input MFB frame open/closed tracker with protocol error detection
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   sof, eof       per-region start/end-of-frame flags of the presented word
//   accept         word is transferred this cycle
//   inframe_next   frame state after this word (equals current state when not accepted)
//   err            protocol violation seen in an accepted word (single-cycle)
module mfb_frame_tracker #(
  parameter int REGIONS = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [REGIONS-1:0] sof,
  input  logic [REGIONS-1:0] eof,
  input  logic               accept,
  output logic               inframe_next,
  output logic               err
);

  logic inframe;
  logic st;
  logic e;

  // Regions are walked in ascending order. A region with both flags set is
  // EOF-then-SOF when a frame is open (stays open) and a complete single
  // frame when closed (stays closed), so the state is unchanged either way.
  always_comb begin
    st = inframe;
    e  = 1'b0;
    for (int r = 0; r < REGIONS; r++) begin
      if (sof[r] && !eof[r]) begin
        if (st) e = 1'b1;
        st = 1'b1;
      end else if (eof[r] && !sof[r]) begin
        if (!st) e = 1'b1;
        st = 1'b0;
      end
    end
    inframe_next = accept ? st : inframe;
    err          = accept & e;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inframe <= 1'b0;
    end else begin
      inframe <= inframe_next;
    end
  end

endmodule

// File: rtl/mfb_merger_arbiter.sv
// rtl/mfb_merger_arbiter.sv - frame-aware round-robin arbiter for a 2-input MFB merger
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   cfg_en[1:0]                   per-input enable, applied at frame boundaries
//   rxN_sof/rxN_eof[REGIONS-1:0]  per-region frame flags of input N
//   rxN_src_rdy / rxN_dst_rdy     input N handshake
//   tx_sel                        datapath mux select (0 = rx0, 1 = rx1)
//   tx_src_rdy / tx_dst_rdy       output handshake
//   cnt_frames0/1                 wrapping counts of accepted EOFs per input
//   err                           sticky SOF/EOF protocol error
module mfb_merger_arbiter
  import mfb_merger_arbiter_pkg::*;
#(
  parameter int REGIONS   = 2,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           cfg_en,
  input  logic [REGIONS-1:0]   rx0_sof,
  input  logic [REGIONS-1:0]   rx0_eof,
  input  logic                 rx0_src_rdy,
  output logic                 rx0_dst_rdy,
  input  logic [REGIONS-1:0]   rx1_sof,
  input  logic [REGIONS-1:0]   rx1_eof,
  input  logic                 rx1_src_rdy,
  output logic                 rx1_dst_rdy,
  output logic                 tx_sel,
  output logic                 tx_src_rdy,
  input  logic                 tx_dst_rdy,
  output logic [CNT_WIDTH-1:0] cnt_frames0,
  output logic [CNT_WIDTH-1:0] cnt_frames1,
  output logic                 err
);

  input_idx_t owner;
  input_idx_t rr_ptr;
  input_idx_t gnt;
  logic       lock;
  logic       gnt_valid;
  logic       lock_next;
  logic       accept;
  logic       acc0;
  logic       acc1;
  logic [1:0] cand;
  logic       if0_next;
  logic       if1_next;
  logic       err0;
  logic       err1;
  logic [MAX_REGIONS-1:0] eof0_ext;
  logic [MAX_REGIONS-1:0] eof1_ext;

  assign eof0_ext = MAX_REGIONS'(rx0_eof);
  assign eof1_ext = MAX_REGIONS'(rx1_eof);

  // An open frame pins the grant to the owner; otherwise pick among enabled,
  // valid inputs, breaking ties with rr_ptr. With nothing to grant, the
  // select keeps pointing at the owner so the datapath does not toggle.
  always_comb begin
    cand      = {rx1_src_rdy & cfg_en[1], rx0_src_rdy & cfg_en[0]};
    gnt       = owner;
    gnt_valid = 1'b0;
    if (lock) begin
      gnt_valid = 1'b1;
    end else begin
      case (cand)
        2'b11: begin gnt = rr_ptr; gnt_valid = 1'b1; end
        2'b01: begin gnt = 1'b0;   gnt_valid = 1'b1; end
        2'b10: begin gnt = 1'b1;   gnt_valid = 1'b1; end
        default: ;
      endcase
    end
  end

  // Handshakes are forced low while reset is held.
  assign tx_sel      = gnt[0];
  assign tx_src_rdy  = reset_n & gnt_valid & (gnt[0] ? rx1_src_rdy : rx0_src_rdy);
  assign rx0_dst_rdy = reset_n & gnt_valid & ~gnt[0] & tx_dst_rdy;
  assign rx1_dst_rdy = reset_n & gnt_valid &  gnt[0] & tx_dst_rdy;
  assign accept      = tx_src_rdy & tx_dst_rdy;
  assign acc0        = accept & ~gnt[0];
  assign acc1        = accept &  gnt[0];
  assign lock_next   = gnt[0] ? if1_next : if0_next;

  mfb_frame_tracker #(.REGIONS(REGIONS)) u_trk0 (
    .clk          (clk),
    .rst_n        (reset_n),
    .sof          (rx0_sof),
    .eof          (rx0_eof),
    .accept       (acc0),
    .inframe_next (if0_next),
    .err          (err0)
  );

  mfb_frame_tracker #(.REGIONS(REGIONS)) u_trk1 (
    .clk          (clk),
    .rst_n        (reset_n),
    .sof          (rx1_sof),
    .eof          (rx1_eof),
    .accept       (acc1),
    .inframe_next (if1_next),
    .err          (err1)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner       <= 1'b0;
      lock        <= 1'b0;
      rr_ptr      <= 1'b0;
      cnt_frames0 <= '0;
      cnt_frames1 <= '0;
      err         <= 1'b0;
    end else begin
      if (accept) begin
        owner <= gnt;
        lock  <= lock_next;
        // A word that leaves the owner closed is a frame boundary: prefer
        // the other input next time both compete.
        if (!lock_next) rr_ptr <= ~gnt;
      end
      if (acc0) cnt_frames0 <= cnt_frames0 + CNT_WIDTH'(popcount(eof0_ext));
      if (acc1) cnt_frames1 <= cnt_frames1 + CNT_WIDTH'(popcount(eof1_ext));
      err <= err | err0 | err1;
    end
  end

endmodule
